// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter: scan-priority arbiter for the single-port pixel RAM.
// Ports: clk_in/reset (async, active low); scan_* read path; host_* write path
// into a FIFO; ram_* RAM side; fifo_count/stall_count/stat_clear statistics;
// swap_req/swap_done bank swap. Optional macro DOUBLE_BUFFER_EN adds the bank bit.
module framebuffer_port_arbiter #(
  parameter int PIXEL_WIDTH  = 64,
  parameter int PIXEL_HEIGHT = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int COL_W = $clog2(PIXEL_WIDTH),
  localparam int ROW_W = $clog2(PIXEL_HEIGHT),
`ifdef DOUBLE_BUFFER_EN
  localparam int BANK  = 1,
`else
  localparam int BANK  = 0,
`endif
  localparam int ADDR_W = BANK + ROW_W + COL_W,
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_req,
  input  logic [ROW_W-1:0]      scan_row,
  input  logic [COL_W-1:0]      scan_col,
  output logic [DATA_WIDTH-1:0] scan_rdata,
  output logic                  scan_rvalid,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ROW_W-1:0]      host_row,
  input  logic [COL_W-1:0]      host_col,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CNT_W-1:0]      fifo_count,
  input  logic                  stat_clear,
  output logic [15:0]           stall_count,
  input  logic                  swap_req,
  output logic                  swap_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ROW_W-1:0]      q_row  [FIFO_DEPTH];
  logic [COL_W-1:0]      q_col  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_pend;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [ADDR_W-1:0]     scan_addr;
  logic [ADDR_W-1:0]     head_addr;

  assign fifo_empty = (fifo_count == '0);
  assign host_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push       = host_valid && host_ready;
  // The scan side owns every cycle it asks for.
  assign pop        = !scan_req && !fifo_empty;

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_row[wr_ptr]  <= host_row;
      q_col[wr_ptr]  <= host_col;
      q_data[wr_ptr] <= host_wdata;
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic q_bank [FIFO_DEPTH];
  logic front;
  logic pending;
  logic frame_start;
  logic swap_fire;
  logic front_nxt;

  assign frame_start = scan_req && (scan_row == '0)
                       && (scan_col == '0);
  // Swap only between frames and only once queued writes
  // have landed in the old back bank.
  assign swap_fire = frame_start && pending && fifo_empty;
  assign front_nxt = front ^ swap_fire;
  assign scan_addr = {front_nxt, scan_row, scan_col};
  assign head_addr = {q_bank[rd_ptr], q_row[rd_ptr],
                      q_col[rd_ptr]};

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_bank[wr_ptr] <= ~front;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      front     <= 1'b0;
      pending   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      front     <= front_nxt;
      swap_done <= swap_fire;
      if (swap_fire) begin
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end
`else
  logic unused_swap_req;

  assign unused_swap_req = swap_req;
  assign swap_done = 1'b0;
  assign scan_addr = {scan_row, scan_col};
  assign head_addr = {q_row[rd_ptr], q_col[rd_ptr]};
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rd_pend     <= 1'b0;
      scan_rvalid <= 1'b0;
      scan_rdata  <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      stall_count <= '0;
    end else begin
      // RAM data is valid one cycle after the address register.
      rd_pend     <= scan_req;
      scan_rvalid <= rd_pend;
      if (rd_pend) begin
        scan_rdata <= ram_rdata;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase

      unique case (1'b1)
        scan_req: begin
          ram_addr <= scan_addr;
          ram_we   <= 1'b0;
        end
        pop: begin
          ram_addr  <= head_addr;
          ram_we    <= 1'b1;
          ram_wdata <= q_data[rd_ptr];
        end
        default: ram_we <= 1'b0;
      endcase

      if (stat_clear) begin
        stall_count <= '0;
      end else if (scan_req && !fifo_empty
                   && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// tb_framebuffer_port_arbiter: randomized and directed bench with a
// queue-based reference model of the framebuffer port arbiter.
module tb_framebuffer_port_arbiter;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int COL_W = 6;
  localparam int ROW_W = 5;
`ifdef DOUBLE_BUFFER_EN
  localparam int BANK  = 1;
`else
  localparam int BANK  = 0;
`endif
  localparam int ADDR_W = BANK + ROW_W + COL_W;
  localparam int CNT_W  = 3;
  localparam int VW = 1 + ADDR_W + DW + 1 + DW + CNT_W + 1 + 16 + 1;

  logic              clk_in;
  logic              reset;
  logic              scan_req;
  logic [ROW_W-1:0]  scan_row;
  logic [COL_W-1:0]  scan_col;
  logic [DW-1:0]     scan_rdata;
  logic              scan_rvalid;
  logic              host_valid;
  logic              host_ready;
  logic [ROW_W-1:0]  host_row;
  logic [COL_W-1:0]  host_col;
  logic [DW-1:0]     host_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              stat_clear;
  logic [15:0]       stall_count;
  logic              swap_req;
  logic              swap_done;

  framebuffer_port_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
    .scan_rdata(scan_rdata), .scan_rvalid(scan_rvalid),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_row(host_row), .host_col(host_col), .host_wdata(host_wdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_count(fifo_count),
    .stat_clear(stat_clear), .stall_count(stall_count),
    .swap_req(swap_req), .swap_done(swap_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM: the arbiter's ram_addr is the address register, data follows it.
  logic [DW-1:0] ram [0:(1<<ADDR_W)-1];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk_in) if (ram_we) ram[ram_addr] <= ram_wdata;

  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  wr_t           wq[$];
  logic [DW-1:0] smem [0:(1<<ADDR_W)-1];
  int            m_addr, m_stall, m_prev_rd;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            m_we, m_rvalid, m_swap, m_front, m_pend, m_prev_req;
  logic [VW-1:0] obs_v, exp_v;
  int            total, bad;

  function automatic logic [DW-1:0] pat(int a);
    return DW'((a * 40503) ^ 23130);
  endfunction

  function automatic int mk(int b, int r, int c);
    return (BANK == 1 ? (b << (ROW_W + COL_W)) : 0) | (r << COL_W) | c;
  endfunction

  task automatic model_reset();
    wq.delete();
    m_addr = 0; m_wdata = '0; m_rdata = '0; m_we = 0; m_rvalid = 0;
    m_stall = 0; m_swap = 0; m_front = 0; m_pend = 0;
    m_prev_req = 0; m_prev_rd = 0;
  endtask

  task automatic zero_inputs();
    scan_req = 0; scan_row = '0; scan_col = '0;
    host_valid = 0; host_row = '0; host_col = '0; host_wdata = '0;
    stat_clear = 0; swap_req = 0;
  endtask

  task automatic sample();
    obs_v = {ram_we, ram_addr, ram_wdata, scan_rvalid, scan_rdata,
             fifo_count, host_ready, stall_count, swap_done};
    exp_v = {m_we, ADDR_W'(m_addr), m_wdata, m_rvalid, m_rdata,
             CNT_W'(wq.size()), wq.size() < DEPTH, 16'(m_stall), m_swap};
  endtask

  // Predict the effect of the coming edge from the current inputs,
  // then take the edge and sample the DUT.
  task automatic tick();
    int  sz;
    bit  fire;
    bit  do_push;
    wr_t e;
    wr_t n;
    sz = wq.size();
    m_rvalid = m_prev_req;
    if (m_prev_req) m_rdata = smem[m_prev_rd];
    do_push = host_valid && (sz < DEPTH);
    n.addr = mk(!m_front, host_row, host_col);
    n.data = host_wdata;
    fire = (BANK == 1) && scan_req && scan_row == 0 && scan_col == 0
           && m_pend && sz == 0;
    m_swap = fire;
    if (fire) begin
      m_front = !m_front;
      m_pend = 0;
    end else if (swap_req && BANK == 1) begin
      m_pend = 1;
    end
    if (stat_clear) m_stall = 0;
    else if (scan_req && sz > 0 && m_stall < 65535) m_stall++;
    if (scan_req) begin
      m_addr = mk(m_front, scan_row, scan_col);
      m_we = 0;
      m_prev_rd = m_addr;
    end else if (sz > 0) begin
      e = wq.pop_front();
      m_addr = e.addr; m_wdata = e.data; m_we = 1;
      smem[e.addr] = e.data;
    end else begin
      m_we = 0;
    end
    if (do_push) wq.push_back(n);
    m_prev_req = scan_req;
    @(posedge clk_in);
    #1;
    sample();
  endtask

  task automatic idle(int n);
    zero_inputs();
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 0;
    zero_inputs();
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs_v, exp_v);
    end
    total++;
    if ({ram_addr, ram_we, scan_rvalid, fifo_count, host_ready,
         stall_count, swap_done} !== {ADDR_W'(0), 1'b0, 1'b0, 3'd0,
         1'b1, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: addr=%h we=%b rv=%b cnt=%0d rdy=%b st=%0d",
               ram_addr, ram_we, scan_rvalid, fifo_count, host_ready,
               stall_count);
    end
  endtask

  task automatic test_reads();
    for (int i = 0; i < 6; i++) begin
      scan_req = (i < 4);
      scan_row = 5'd3;
      scan_col = 6'(5 + i);
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reads_model i=%0d: got %h want %h", i, obs_v, exp_v);
      end
      total++;
      if (i >= 1 && i <= 4) begin
        if (scan_rvalid !== 1'b1 || scan_rdata !== pat(mk(0, 3, 4 + i))
            || ram_we !== 1'b0) begin
          bad++;
          $display("FAIL reads_data i=%0d: rv=%b data=%h we=%b want rv=1 data=%h we=0",
                   i, scan_rvalid, scan_rdata, ram_we, pat(mk(0, 3, 4 + i)));
        end
      end else if (scan_rvalid !== 1'b0 || ram_we !== 1'b0) begin
        bad++;
        $display("FAIL reads_idle i=%0d: rv=%b we=%b want 0 0",
                 i, scan_rvalid, ram_we);
      end
    end
    zero_inputs();
  endtask

  task automatic test_write_during_scan();
    logic [DW-1:0] d;
    d = 16'hC3A5;
    scan_req = 1; scan_row = 5'd1; scan_col = 6'd1;
    host_valid = 1; host_row = 5'd7; host_col = 6'd9; host_wdata = d;
    stat_clear = 1;
    tick();
    host_valid = 0; stat_clear = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (obs_v !== exp_v || ram_we !== 1'b0) begin
        bad++;
        $display("FAIL wds_blocked i=%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    total++;
    if (stall_count !== 16'd10 || fifo_count !== 3'd1) begin
      bad++;
      $display("FAIL wds_stall: stall=%0d cnt=%0d want 10 1",
               stall_count, fifo_count);
    end
    scan_req = 0;
    tick();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(mk(1, 7, 9))
        || ram_wdata !== d || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL wds_drain: we=%b addr=%h data=%h cnt=%0d want 1 %h %h 0",
               ram_we, ram_addr, ram_wdata, fifo_count, mk(1, 7, 9), d);
    end
    idle(2);
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = DW'($urandom);
    scan_req = 1; scan_row = 5'd2; scan_col = 6'd1;
    for (int i = 0; i < 5; i++) begin
      host_valid = 1; host_row = 5'(i + 1); host_col = 6'(2 * i);
      host_wdata = d[i];
      tick();
      total++;
      if (obs_v !== exp_v
          || fifo_count !== CNT_W'(i + 1 > 4 ? 4 : i + 1)
          || host_ready !== (i + 1 < 4)) begin
        bad++;
        $display("FAIL full_fill i=%0d: cnt=%0d rdy=%b got %h want %h",
                 i, fifo_count, host_ready, obs_v, exp_v);
      end
    end
    scan_req = 0;
    for (int j = 0; j < 5; j++) begin
      host_valid = (j < 2);
      tick();
      total++;
      if (obs_v !== exp_v || ram_we !== 1'b1 || ram_wdata !== d[j]
          || (j == 0 && fifo_count !== 3'd3)) begin
        bad++;
        $display("FAIL full_drain j=%0d: we=%b data=%h cnt=%0d want data %h",
                 j, ram_we, ram_wdata, fifo_count, d[j]);
      end
    end
    idle(2);
  endtask

  task automatic test_saturation();
    scan_req = 1; scan_row = 5'd1; scan_col = 6'd2;
    host_valid = 1; host_row = 5'd4; host_col = 6'd4;
    host_wdata = 16'h1234; stat_clear = 1;
    tick();
    host_valid = 0; stat_clear = 0;
    for (int n = 1; n <= 65537; n++) begin
      tick();
      if (n == 65534) begin
        total++;
        if (stall_count !== 16'hFFFE) begin
          bad++;
          $display("FAIL sat_near: stall=%h want fffe", stall_count);
        end
      end
      if (n == 65535 || n == 65537) begin
        total++;
        if (stall_count !== 16'hFFFF || obs_v !== exp_v) begin
          bad++;
          $display("FAIL sat_hold n=%0d: stall=%h want ffff", n, stall_count);
        end
      end
    end
    stat_clear = 1;
    tick();
    total++;
    if (stall_count !== 16'd0 || fifo_count !== 3'd1) begin
      bad++;
      $display("FAIL sat_clear: stall=%h cnt=%0d want 0 1",
               stall_count, fifo_count);
    end
    idle(3);
  endtask

  task automatic test_async_reset();
    scan_req = 1; scan_row = 5'd4; scan_col = 6'd4;
    host_valid = 1; host_row = 5'd6; host_col = 6'd6; host_wdata = 16'hBEEF;
    tick();
    host_valid = 0; scan_col = 6'd5;
    tick();
    total++;
    if (scan_rvalid !== 1'b1 || obs_v !== exp_v) begin
      bad++;
      $display("FAIL arst_pre: rv=%b got %h want %h", scan_rvalid, obs_v, exp_v);
    end
    scan_req = 0;
    #3;
    reset = 0;
    model_reset();
    #1;
    total++;
    if (scan_rvalid !== 1'b0 || fifo_count !== 3'd0 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL arst_now: rv=%b cnt=%0d we=%b want 0 0 0",
               scan_rvalid, fifo_count, ram_we);
    end
    @(posedge clk_in);
    #1;
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (ram_we !== 1'b0 || obs_v !== exp_v) begin
        bad++;
        $display("FAIL arst_after i=%0d: we=%b got %h want %h",
                 i, ram_we, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      scan_req = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) begin
        scan_row = '0; scan_col = '0;
      end else begin
        scan_row = 5'($urandom_range(0, 31));
        scan_col = 6'($urandom_range(0, 63));
      end
      host_valid = 1'($urandom_range(0, 1));
      host_row = 5'($urandom_range(0, 31));
      host_col = 6'($urandom_range(0, 63));
      host_wdata = DW'($urandom);
      stat_clear = ($urandom_range(0, 63) == 0);
      swap_req = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL random i=%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    idle(8);
  endtask

`ifdef DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    do_reset();
    scan_req = 1; scan_row = 5'd5; scan_col = 6'd5;
    host_valid = 1; host_row = 5'd9; host_col = 6'd3; host_wdata = 16'hBEEF;
    swap_req = 1;
    tick();
    host_valid = 0; swap_req = 0; scan_row = '0; scan_col = '0;
    tick();
    total++;
    if (swap_done !== 1'b0 || ram_addr !== ADDR_W'(mk(0, 0, 0))
        || obs_v !== exp_v) begin
      bad++;
      $display("FAIL db_defer: sd=%b addr=%h want 0 %h",
               swap_done, ram_addr, mk(0, 0, 0));
    end
    scan_req = 0;
    tick();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(mk(1, 9, 3))) begin
      bad++;
      $display("FAIL db_drain: we=%b addr=%h want 1 %h",
               ram_we, ram_addr, mk(1, 9, 3));
    end
    scan_req = 1;
    tick();
    total++;
    if (swap_done !== 1'b1 || ram_addr !== ADDR_W'(mk(1, 0, 0))
        || obs_v !== exp_v) begin
      bad++;
      $display("FAIL db_swap: sd=%b addr=%h want 1 %h",
               swap_done, ram_addr, mk(1, 0, 0));
    end
    scan_req = 0;
    host_valid = 1; host_row = 5'd2; host_col = 6'd2; host_wdata = 16'h0F0F;
    tick();
    total++;
    if (swap_done !== 1'b0) begin
      bad++;
      $display("FAIL db_pulse: sd=%b want 0", swap_done);
    end
    host_valid = 0;
    tick();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(mk(0, 2, 2))) begin
      bad++;
      $display("FAIL db_back: we=%b addr=%h want 1 %h",
               ram_we, ram_addr, mk(0, 2, 2));
    end
    idle(2);
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 0;
    zero_inputs();
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      ram[a] = pat(a);
      smem[a] = pat(a);
    end
    test_reset();
    test_reads();
    test_write_during_scan();
    test_fifo_full();
    test_saturation();
    test_async_reset();
    test_random();
`ifdef DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_port_arbiter.md
Name: framebuffer_port_arbiter

Overview:
- Shares the single-port pixel framebuffer RAM between two requesters.
- The matrix scan pixel fetch has absolute priority and fixed latency.
- The host write path is buffered in a small FIFO and drains only in cycles the scan side leaves free.
- Sits between the row/column address generator feeding the pixel shift-out and the UART/command write side; also reports write-stall statistics.

Parameters:
- PIXEL_WIDTH, 64, columns per row; COL_W = $clog2(PIXEL_WIDTH).
- PIXEL_HEIGHT, 32, rows per frame; ROW_W = $clog2(PIXEL_HEIGHT).
- DATA_WIDTH, 16, bits per stored pixel.
- FIFO_DEPTH, 4, host write FIFO entries; power of two, at least 2.

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous active-low reset
- scan_req  input  1  scan read request this cycle
- scan_row  input  ROW_W  scan read row
- scan_col  input  COL_W  scan read column
- scan_rdata  output  DATA_WIDTH  read data
- scan_rvalid  output  1  scan_rdata valid
- host_valid  input  1  host write offered
- host_ready  output  1  FIFO can accept
- host_row  input  ROW_W  write row
- host_col  input  COL_W  write column
- host_wdata  input  DATA_WIDTH  write data
- ram_addr  output  BANK+ROW_W+COL_W  RAM address {bank?, row, col}; BANK=1 with DOUBLE_BUFFER_EN, else 0
- ram_we  output  1  RAM write strobe
- ram_wdata  output  DATA_WIDTH  RAM write data
- ram_rdata  input  DATA_WIDTH  RAM read data, 1-cycle latency after ram_addr
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- stat_clear  input  1  synchronous clear of stall_count
- stall_count  output  16  cycles a queued write was blocked by scan
- swap_req  input  1  request front/back bank swap; ignored without macro
- swap_done  output  1  one-cycle pulse when a swap takes effect

Behaviour:
- Reset (async assert, sync release): ram_addr=0, ram_we=0, ram_wdata=0, scan_rdata=0, scan_rvalid=0, FIFO empty, fifo_count=0, stall_count=0, swap_done=0, front bank=0, swap pending=0.
- host_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
- Push when host_valid && host_ready; the entry is {row, col, wdata[, bank]}.
- Edge k with scan_req=1:
  - ram_addr <= {front, scan_row, scan_col}; ram_we <= 0.
  - At edge k+1, scan_rdata <= ram_rdata and scan_rvalid <= 1. scan_rvalid is therefore high in exactly the 2nd cycle after the request cycle.
  - Back-to-back requests give back-to-back rvalid.
- Edge k with scan_req=0 and FIFO non-empty: pop the head; ram_addr <= {entry bank, row, col}; ram_we <= 1; ram_wdata <= data.
- Edge k with scan_req=0 and FIFO empty: ram_we <= 0; ram_addr holds.
- A write is never issued in a scan_req cycle; the scan side is never delayed.
- Simultaneous push and pop in one cycle: count unchanged, ordering preserved. A push in the same cycle the FIFO is full is refused even if a pop occurs.
- FIFO pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- stall_count: increments each cycle with scan_req=1 and FIFO non-empty; saturates at 16'hFFFF; stat_clear has priority and sets it to 0.
- Writes are issued strictly in push order; there is no reordering or merging of same-address writes.
- Reset mid-operation discards the FIFO and aborts any in-flight read; scan_rvalid drops immediately on assert.

Optional Feature:
- Macro DOUBLE_BUFFER_EN.
- With the macro:
  - ram_addr gains the MSB bank bit.
  - Scan reads use front; host pushes are tagged with back = ~front, captured at push time.
  - swap_req (level or pulse) sets pending.
  - The swap applies at the edge sampling scan_req=1 with scan_row=0, scan_col=0 (frame start), only if pending=1 and the FIFO is empty.
  - When it applies, front toggles before that read is addressed, so the read uses the new front; pending clears; swap_done pulses for 1 cycle.
  - If the FIFO is non-empty, the swap defers to the next qualifying frame start.
- Without the macro: single bank, swap_req ignored, swap_done tied 0, no bank bit in ram_addr or FIFO entries.

Test Plan:
- Reads only: scan_req=1 for row 3, col 5..8 consecutive with RAM model -> scan_rvalid high cycles k+2..k+5, data of addresses {3,5}..{3,8} in order, ram_we=0 throughout.
- Write during scan: push 1 write, hold scan_req=1 for 10 cycles -> ram_we stays 0, stall_count=10; scan_req drops -> ram_we=1 next edge with the pushed address/data, fifo_count 1->0.
- FIFO full: scan_req=1 held, push 5 writes -> host_ready low after the 4th, fifo_count=4, 5th not accepted until a pop; release scan -> 4 writes issued in push order on consecutive cycles.
- Saturation and clear: force 70000 blocked cycles -> stall_count=16'hFFFF; stat_clear with blocked write in same cycle -> 0.
- Async reset mid-read: assert reset between request and rvalid -> scan_rvalid=0 immediately, fifo_count=0, no ram_we after release.
- DOUBLE_BUFFER_EN: swap_req with FIFO holding 1 write at frame start -> no swap; write drains to bank 1; next frame start -> swap_done pulse, that read addresses bank 1, subsequent host writes target bank 0.
